des3_bist_ctrl: RTL and testbench

DES3_BIST_CTRL -- requirements
Module: des3_bist_ctrl

---
 rtl/des3_bist_pkg.sv | 28 ++
 rtl/des3_lfsr8.sv | 13 +
 rtl/des3_bist_ctrl.sv | 146 ++++++++++++++
 tb/tb_des3_bist_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/des3_bist_pkg.sv
// des3_bist_pkg -- shared types and constants for the 3DES BIST controller.
//   bist_state_e : controller FSM states
//   DEC_MODE_*   : dec_mode encodings (encrypt / decrypt / alternate)
//   LFSR_W       : lane width of the pattern generator
//   LFSR_TAPS    : taps b[7],b[5],b[4],b[3]; feedback is inverted (XNOR) so
//                  the all-zero state is a legal start point
package des3_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } bist_state_e;

  localparam logic [1:0] DEC_MODE_ENC   = 2'b00;
  localparam logic [1:0] DEC_MODE_DEC   = 2'b01;
  localparam logic [1:0] DEC_MODE_ALT   = 2'b10;
  localparam logic [1:0] DEC_MODE_ALT_B = 2'b11;

  localparam int              LFSR_W    = 8;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;

  // One lane step: shift left, XNOR of the tapped bits enters at bit 0.
  function automatic logic [LFSR_W-1:0] lfsr8_step(input logic [LFSR_W-1:0] b);
    return {b[LFSR_W-2:0], ~^(b & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/des3_lfsr8.sv
// des3_lfsr8 -- combinational single step of one 8-bit pattern lane.
//   i_b : current lane value
//   o_b : lane value after one LFSR step
module des3_lfsr8
  import des3_bist_pkg::*;
(
  input  logic [LFSR_W-1:0] i_b,
  output logic [LFSR_W-1:0] o_b
);

  assign o_b = lfsr8_step(i_b);

endmodule

// File: rtl/des3_bist_ctrl.sv
// des3_bist_ctrl -- BIST sequencer for a 3DES core.
// Drives pattern vectors (desIn) and keys from per-byte LFSR lanes, holds each
// vector WAIT_CYCLES+1 cycles, then compacts desOut into a rotating MISR.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   start       : begin a run (honoured in IDLE and DONE only)
//   dec_mode    : 00 encrypt, 01 decrypt, 1x alternate starting with encrypt
//   desOut      : cipher result, captured on the last cycle of each vector
//   decrypt     : direction for the current vector
//   desIn, keys : current vector / key set (key i at keys[KEY_W*i +: KEY_W])
//   busy, done  : RUN / DONE status
//   signature   : compacted response
//   vec_count   : index of the current vector
// Build option: define DES3_BIST_MISR_EN to build the signature register;
// otherwise signature is tied to 0 and desOut is ignored.
module des3_bist_ctrl
  import des3_bist_pkg::*;
#(
  parameter int DATA_W      = 64,
  parameter int KEY_W       = 56,
  parameter int NUM_KEYS    = 3,
  parameter int WAIT_CYCLES = 30,
  parameter int NUM_VECTORS = 256
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [1:0]                dec_mode,
  input  logic [DATA_W-1:0]         desOut,
  output logic                      decrypt,
  output logic [DATA_W-1:0]         desIn,
  output logic [NUM_KEYS*KEY_W-1:0] keys,
  output logic                      busy,
  output logic                      done,
  output logic [DATA_W-1:0]         signature,
  output logic [15:0]               vec_count
);

  localparam int TOT_W     = DATA_W + NUM_KEYS*KEY_W;
  localparam int NUM_LANES = TOT_W / LFSR_W;
  localparam int CNT_W     = ($clog2(WAIT_CYCLES+1) > 5) ? $clog2(WAIT_CYCLES+1) : 5;

  if ((TOT_W % LFSR_W) != 0) begin : g_bad_width
    $error("des3_bist_ctrl: DATA_W + NUM_KEYS*KEY_W must be a multiple of 8");
  end
  if (NUM_VECTORS < 1 || NUM_VECTORS > 65535) begin : g_bad_nvec
    $error("des3_bist_ctrl: NUM_VECTORS must be in 1..65535");
  end

  bist_state_e        r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [15:0]        r_vec, w_vec_nxt;
  logic [TOT_W-1:0]   r_lfsr, w_lfsr_nxt, w_lfsr_step;
  logic               r_dec, w_dec_nxt;
  logic               w_capture, w_last_vec, w_alt;

  // {keys, desIn} packed as byte lanes, each stepped independently.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    des3_lfsr8 u_lane (
      .i_b(r_lfsr[LFSR_W*i +: LFSR_W]),
      .o_b(w_lfsr_step[LFSR_W*i +: LFSR_W])
    );
  end

  assign w_capture  = (r_state == ST_RUN) && (r_cnt == CNT_W'(WAIT_CYCLES));
  assign w_last_vec = (r_vec == 16'(NUM_VECTORS-1));
  assign w_alt      = (dec_mode == DEC_MODE_ALT) || (dec_mode == DEC_MODE_ALT_B);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_vec_nxt   = r_vec;
    w_lfsr_nxt  = r_lfsr;
    w_dec_nxt   = r_dec;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = '0;
          w_vec_nxt   = '0;
          w_lfsr_nxt  = '0;
          w_dec_nxt   = (dec_mode == DEC_MODE_DEC);
        end
      end
      ST_RUN: begin
        if (!w_capture) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end else if (w_last_vec) begin
          // Final capture: vector state freezes for inspection in DONE.
          w_state_nxt = ST_DONE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt  = '0;
          w_vec_nxt  = r_vec + 16'd1;
          w_lfsr_nxt = w_lfsr_step;
          if (w_alt) w_dec_nxt = ~r_dec;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_vec   <= '0;
      r_lfsr  <= '0;
      r_dec   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_vec   <= w_vec_nxt;
      r_lfsr  <= w_lfsr_nxt;
      r_dec   <= w_dec_nxt;
    end
  end

`ifdef DES3_BIST_MISR_EN
  logic [DATA_W-1:0] r_sig;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sig <= '0;
    end else if ((r_state != ST_RUN) && start) begin
      r_sig <= '0;
    end else if (w_capture) begin
      r_sig <= {r_sig[DATA_W-2:0], r_sig[DATA_W-1]} ^ desOut;
    end
  end

  assign signature = r_sig;
`else
  logic w_unused_desout;
  assign w_unused_desout = ^desOut;
  assign signature       = '0;
`endif

  assign desIn     = r_lfsr[DATA_W-1:0];
  assign keys      = r_lfsr[TOT_W-1:DATA_W];
  assign decrypt   = r_dec;
  assign busy      = (r_state == ST_RUN);
  assign done      = (r_state == ST_DONE);
  assign vec_count = r_vec;

endmodule

// File: tb/tb_des3_bist_ctrl.sv
module tb_des3_bist_ctrl;
  localparam int DW = 64, KW = 56, NK = 3, WC = 30, NV = 4;
  localparam int LANES_D = DW/8, LANES_K = NK*KW/8;
  localparam int VCYC = WC + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1, start = 1'b0;
  logic [1:0]        dec_mode = 2'b00;
  logic [DW-1:0]     desOut = '0;
  logic              decrypt, busy, done;
  logic [DW-1:0]     desIn, signature;
  logic [NK*KW-1:0]  keys;
  logic [15:0]       vec_count;

  always #5 clk = ~clk;

  des3_bist_ctrl #(.DATA_W(DW), .KEY_W(KW), .NUM_KEYS(NK), .WAIT_CYCLES(WC),
                   .NUM_VECTORS(NV)) dut (
    .clk(clk), .rst(rst), .start(start), .dec_mode(dec_mode), .desOut(desOut),
    .decrypt(decrypt), .desIn(desIn), .keys(keys), .busy(busy), .done(done),
    .signature(signature), .vec_count(vec_count));

  int n_chk = 0, n_fail = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  // Lane value after n advances from the all-zero start.
  function automatic logic [7:0] lane_after(input int n);
    logic [7:0] b = 8'h00;
    for (int i = 0; i < n; i++) b = {b[6:0], ~(b[7] ^ b[5] ^ b[4] ^ b[3])};
    return b;
  endfunction

  // Behavioural model: phase 0 idle, 1 running, 2 finished.
  int          m_ph = 0, m_cyc = 0, m_vec = 0;
  logic [1:0]  m_mode = 2'b00;
  logic [DW-1:0] m_sig = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_ph <= 0; m_cyc <= 0; m_vec <= 0; m_mode <= 2'b00; m_sig <= '0;
    end else if (m_ph != 1) begin
      if (start) begin
        m_ph <= 1; m_cyc <= 0; m_vec <= 0; m_mode <= dec_mode; m_sig <= '0;
      end
    end else if (m_cyc < WC) begin
      m_cyc <= m_cyc + 1;
    end else begin
      m_sig <= {m_sig[DW-2:0], m_sig[DW-1]} ^ desOut;
      m_cyc <= 0;
      if (m_vec == NV-1) m_ph <= 2;
      else m_vec <= m_vec + 1;
    end
  end

  function automatic logic [DW-1:0] exp_sig();
`ifdef DES3_BIST_MISR_EN
    return m_sig;
`else
    return '0;
`endif
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      logic [7:0] lv;
      logic       ed;
      lv = lane_after(m_vec);
      // Direction from the run's mode and vector index (alternate: odd = decrypt).
      ed = (m_mode == 2'b01) || (m_mode[1] && (m_vec % 2 == 1));
      check("m_busy", busy, m_ph == 1);
      check("m_done", done, m_ph == 2);
      check("m_desIn", desIn, {LANES_D{lv}});
      check("m_keys", keys, {LANES_K{lv}});
      check("m_decrypt", decrypt, ed);
      check("m_vec_count", vec_count, m_vec[15:0]);
      check("m_signature", signature, exp_sig());
    end
  end

  task automatic pulse_start(input logic [1:0] m);
    @(negedge clk); dec_mode = m; start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic run_to_done(input bit rnd_out, input bit rnd_start);
    int k = 0;
    while (done !== 1'b1 && k < NV*VCYC + 10) begin
      @(negedge clk);
      if (rnd_out) desOut = {$urandom, $urandom};
      if (rnd_start) start = ($urandom_range(0, 7) == 0);
      k++;
    end
    start = 1'b0;
    check("done_reached", done, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] ref_sig;
    logic [3:0] dec_seq;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0; cmp_en = 1'b1;
    check("rst_busy", busy, 1'b0);
    check("rst_desIn", desIn, '0);
    check("rst_sig", signature, '0);

    // Default pattern progression, desOut held at 1.
    desOut = 64'h1;
    pulse_start(2'b00);
    check("start_busy", busy, 1'b1);
    check("start_desIn", desIn, '0);
    check("start_keys", keys, '0);
    check("start_decrypt", decrypt, 1'b0);
    repeat (VCYC) @(negedge clk);
    check("v1_desIn", desIn, 64'h0101010101010101);
    check("v1_key0", keys[55:0], 56'h01010101010101);
    check("v1_key2", keys[167:112], 56'h01010101010101);
    check("v1_vec", vec_count, 16'd1);
    repeat (VCYC) @(negedge clk);
    check("v2_desIn", desIn, 64'h0303030303030303);
    check("v2_key1", keys[111:56], 56'h03030303030303);
    repeat (VCYC) @(negedge clk);
    check("v3_desIn", desIn, 64'h0707070707070707);
    check("v3_vec", vec_count, 16'd3);
    repeat (VCYC) @(negedge clk);
    check("nv4_done", done, 1'b1);
    check("nv4_busy", busy, 1'b0);
`ifdef DES3_BIST_MISR_EN
    check("nv4_sig", signature, 64'hF);
`else
    check("nv4_sig", signature, 64'h0);
`endif

    // Alternating direction: 0,1,0,1.
    dec_seq = 4'b1010;
    pulse_start(2'b10);
    for (int v = 0; v < NV; v++) begin
      check("alt_decrypt", decrypt, dec_seq[v]);
      if (v < NV-1) repeat (VCYC) @(negedge clk);
    end
    run_to_done(1'b1, 1'b0);

    // Decrypt-only.
    pulse_start(2'b01);
    check("dec_first", decrypt, 1'b1);
    run_to_done(1'b1, 1'b0);
    check("dec_last", decrypt, 1'b1);

    // Reset at vector 2, cycle 10.
    pulse_start(2'b11);
    repeat (2*VCYC + 10) @(negedge clk);
    check("pre_rst_vec", vec_count, 16'd2);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_desIn", desIn, '0);
    check("mid_rst_keys", keys, '0);
    check("mid_rst_dec", decrypt, 1'b0);
    check("mid_rst_vec", vec_count, 16'd0);
    check("mid_rst_sig", signature, '0);
    pulse_start(2'b00);
    check("restart_vec", vec_count, 16'd0);
    check("restart_busy", busy, 1'b1);
    run_to_done(1'b0, 1'b0);

    // Rerun from DONE with identical response and stray start pulses.
    desOut = {$urandom, $urandom};
    pulse_start(2'b11);
    run_to_done(1'b0, 1'b1);
    ref_sig = exp_sig();
    pulse_start(2'b11);
    run_to_done(1'b0, 1'b1);
    check("rerun_sig", signature, ref_sig);

    // Randomized runs.
    for (int r = 0; r < 6; r++) begin
      pulse_start(2'($urandom_range(0, 3)));
      run_to_done(1'b1, 1'b1);
      repeat ($urandom_range(0, 5)) @(negedge clk);
    end

    @(negedge clk);
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
